// File: rtl/d_sram_like_bridge_wbuf_pkg.sv
// Shared constants and helpers for the data-side SRAM-like bridge.
// Holds the bus FSM encodings, the transfer size codes and the byte-enable to size decoder.
package d_bridge_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrReq  = 3'd1;
  localparam logic [2:0] StWrWait = 3'd2;
  localparam logic [2:0] StRdReq  = 3'd3;
  localparam logic [2:0] StRdWait = 3'd4;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // wen is zero-extended to 8 lanes; patterns that are not naturally aligned fall back to full width
  function automatic logic [1:0] wen_to_size(input logic [7:0] wen, input int unsigned strb_w);
    logic [1:0] full;
    full = (strb_w == 8) ? SIZE_D : SIZE_W;
    if (wen != 8'h00 && (wen & (wen - 8'h01)) == 8'h00) begin
      return SIZE_B;
    end
    if (wen == 8'h03 || wen == 8'h0c || wen == 8'h30 || wen == 8'hc0) begin
      return SIZE_H;
    end
    if (wen == 8'h0f || wen == 8'hf0) begin
      return SIZE_W;
    end
    return full;
  endfunction

endpackage

// File: rtl/d_sram_like_bridge_wbuf_if.sv
// SRAM-like bus between the data bridge (master) and the AXI adapter (slave).
interface d_sram_like_bridge_wbuf_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_addr_ok;
  logic              data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/d_sram_like_bridge_wbuf_fifo.sv
// Synchronous FIFO backing the posted write buffer.
// A pop on a full FIFO frees its slot for a push in the same cycle.
module wbuf_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CountFull);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/d_sram_like_bridge_wbuf.sv
// Data-side SRAM to SRAM-like bridge with a posted write buffer.
// Stores retire through the buffer; loads wait for the buffer to drain, then issue one read.
module d_sram_like_bridge_wbuf
  import d_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_sram_en,
  input  logic [ADDR_W-1:0]     data_sram_addr,
  input  logic [DATA_W/8-1:0]   data_sram_wen,
  input  logic [DATA_W-1:0]     data_sram_wdata,
  output logic [DATA_W-1:0]     data_sram_rdata,
  output logic                  d_stall,
  input  logic                  longest_stall,
  d_sram_like_bridge_wbuf_if.master bus,
  output logic                  wbuf_empty
);
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned ENTRY_W = ADDR_W + 2 + DATA_W;
  localparam logic [1:0]  SIZE_FULL = (DATA_W == 64) ? SIZE_D : SIZE_W;
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(STRB_W - 1);

  logic [2:0]         state_q, state_d;
  logic               st_acc_q, st_acc_d;
  logic               ld_done_q, ld_done_d;
  logic [DATA_W-1:0]  rdata_q;
  logic [ADDR_W-1:0]  rd_addr_q;

  logic               is_store, is_load;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic               rd_ok;
  logic [7:0]         wen_ext;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic [ADDR_W-1:0]  head_addr;
  logic [1:0]         head_size;
  logic [DATA_W-1:0]  head_wdata;
  logic               in_wr, in_rd;

  assign wen_ext  = 8'(data_sram_wen);
  assign is_store = data_sram_en & (|data_sram_wen);
  assign is_load  = data_sram_en & ~(|data_sram_wen);

  assign in_wr = (state_q == StWrReq) | (state_q == StWrWait);
  assign in_rd = (state_q == StRdReq) | (state_q == StRdWait);

  assign fifo_pop = ((state_q == StWrReq) & bus.data_addr_ok & bus.data_data_ok) |
                    ((state_q == StWrWait) & bus.data_data_ok);
  assign rd_ok    = ((state_q == StRdReq) & bus.data_addr_ok & bus.data_data_ok) |
                    ((state_q == StRdWait) & bus.data_data_ok);

  // st_acc marks a store already queued while the pipeline still holds it
  assign fifo_push  = is_store & ~st_acc_q & (~fifo_full | fifo_pop);
  assign push_entry = {data_sram_addr, wen_to_size(wen_ext, STRB_W), data_sram_wdata};
  assign {head_addr, head_size, head_wdata} = head_entry;

  wbuf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WBUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .head  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StWrReq;
        end else if (is_load && !ld_done_q) begin
          state_d = StRdReq;
        end
      end
      StWrReq: begin
        if (bus.data_addr_ok) state_d = bus.data_data_ok ? StIdle : StWrWait;
      end
      StWrWait: begin
        if (bus.data_data_ok) state_d = StIdle;
      end
      StRdReq: begin
        if (bus.data_addr_ok) state_d = bus.data_data_ok ? StIdle : StRdWait;
      end
      StRdWait: begin
        if (bus.data_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign st_acc_d  = longest_stall & (st_acc_q | fifo_push);
  assign ld_done_d = rd_ok | (longest_stall & ld_done_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      st_acc_q  <= 1'b0;
      ld_done_q <= 1'b0;
      rdata_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      st_acc_q  <= st_acc_d;
      ld_done_q <= ld_done_d;
      if (rd_ok) rdata_q <= bus.data_rdata;
      if (state_q == StIdle && state_d == StRdReq) begin
        rd_addr_q <= data_sram_addr & AlignMask;
      end
    end
  end

  assign bus.data_req   = (state_q == StWrReq) | (state_q == StRdReq);
  assign bus.data_wr    = in_wr;
  assign bus.data_size  = in_rd ? SIZE_FULL : head_size;
  assign bus.data_addr  = in_rd ? rd_addr_q : head_addr;
  assign bus.data_wdata = head_wdata;

  assign data_sram_rdata = rdata_q;
  assign d_stall = (is_store & ~st_acc_q & fifo_full & ~fifo_pop) | (is_load & ~ld_done_q);
  assign wbuf_empty = fifo_empty & ~in_wr;

endmodule
